// File: rtl/multicycle_control_pkg.sv
// multicycle_control_pkg: shared state, opcode-class and select encodings for the multi-cycle RV32I controller
// Provides: state_t, op_class_t, RV32I opcode constants, pc_src/wb_sel/alu_a_sel/alu_b_sel/alu_op_mode
// encodings and the branch-condition helper branch_taken().
package multicycle_control_pkg;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    typedef enum logic [3:0] {
        CL_ILL,
        CL_LOAD,
        CL_STORE,
        CL_OPIMM,
        CL_R,
        CL_BRANCH,
        CL_JAL,
        CL_JALR,
        CL_LUI,
        CL_AUIPC
    } op_class_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;
    localparam logic [2:0] F3_BLT = 3'b100;
    localparam logic [2:0] F3_BGE = 3'b101;

    localparam logic [1:0] PC_PLUS4  = 2'd0;
    localparam logic [1:0] PC_BRANCH = 2'd1;
    localparam logic [1:0] PC_ALU    = 2'd2;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;

    localparam logic [1:0] A_RS1  = 2'd0;
    localparam logic [1:0] A_PC   = 2'd1;
    localparam logic [1:0] A_ZERO = 2'd2;

    localparam logic B_RS2 = 1'b0;
    localparam logic B_IMM = 1'b1;

    localparam logic [1:0] MODE_ADD   = 2'd0;
    localparam logic [1:0] MODE_FUNCT = 2'd1;
    localparam logic [1:0] MODE_SUB   = 2'd2;

    // Unsupported branch funct3 values (BLTU/BGEU and reserved) fall through as not taken.
    function automatic logic branch_taken(input logic [2:0] f3, input logic zero, input logic lt);
        return (f3 == F3_BEQ) ? zero :
               (f3 == F3_BNE) ? !zero :
               (f3 == F3_BLT) ? lt :
               (f3 == F3_BGE) ? !lt : 1'b0;
    endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// multicycle_control_if: memory request handshake between the controller and the memory port
// mem_req/mem_we/mem_iaddr driven by the controller (master); mem_ready returned by memory (slave).
interface multicycle_control_if;
    logic mem_req;
    logic mem_we;
    logic mem_iaddr;
    logic mem_ready;
    modport master (output mem_req, output mem_we, output mem_iaddr, input mem_ready);
    modport slave  (input mem_req, input mem_we, input mem_iaddr, output mem_ready);
endinterface

// File: rtl/mc_op_class.sv
// mc_op_class: combinational RV32I opcode -> instruction class mapper
// Ports: opcode[6:0] in, op_class out (CL_ILL for any opcode outside the supported set).
module mc_op_class
    import multicycle_control_pkg::*;
(
    input  logic [6:0] opcode,
    output op_class_t  op_class
);
    always_comb
        op_class = (opcode == OP_LOAD)   ? CL_LOAD   :
                   (opcode == OP_STORE)  ? CL_STORE  :
                   (opcode == OP_OPIMM)  ? CL_OPIMM  :
                   (opcode == OP_R)      ? CL_R      :
                   (opcode == OP_BRANCH) ? CL_BRANCH :
                   (opcode == OP_JAL)    ? CL_JAL    :
                   (opcode == OP_JALR)   ? CL_JALR   :
                   (opcode == OP_LUI)    ? CL_LUI    :
                   (opcode == OP_AUIPC)  ? CL_AUIPC  : CL_ILL;
endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: fetch/decode/execute/memory/writeback sequencer for the multi-cycle RV32I core
// Ports: clk, rst (sync, active-high); mem (multicycle_control_if.master: mem_req/mem_we/mem_iaddr out,
// mem_ready in); opcode/funct3 from IR; alu_zero/alu_lt flags; ir_write, pc_write, pc_src, reg_write,
// wb_sel, alu_a_sel, alu_b_sel, alu_op_mode, retire, halted, bus_error outputs.
// Optional macro MC_ILLEGAL_TRAP_EN: unknown opcodes halt the core and raise sticky illegal_insn
// instead of retiring as a NOP.
module multicycle_control
    import multicycle_control_pkg::*;
#(
    parameter int MEM_WAIT_MAX = 255,
    parameter int CNT_W        = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    multicycle_control_if.master        mem,
    input  logic [6:0]                  opcode,
    input  logic [2:0]                  funct3,
    input  logic                        alu_zero,
    input  logic                        alu_lt,
    output logic                        ir_write,
    output logic                        pc_write,
    output logic [1:0]                  pc_src,
    output logic                        reg_write,
    output logic [1:0]                  wb_sel,
    output logic [1:0]                  alu_a_sel,
    output logic                        alu_b_sel,
    output logic [1:0]                  alu_op_mode,
    output logic                        retire,
    output logic                        halted,
    output logic                        bus_error
`ifdef MC_ILLEGAL_TRAP_EN
    ,
    output logic                        illegal_insn
`endif
);
    state_t            state, state_n;
    op_class_t         cls, dec_cls;
    logic [CNT_W-1:0]  cnt;
    logic              armed, timeout, jump;

    mc_op_class u_op_class (.opcode(opcode), .op_class(dec_cls));

    // armed stays low for the first cycle after reset so no request is issued in that cycle.
    assign timeout = (MEM_WAIT_MAX != 0) && ((state == S_FETCH && armed) || state == S_MEM)
                     && cnt == CNT_W'(MEM_WAIT_MAX);
    assign jump    = cls == CL_JAL || cls == CL_JALR;
    assign halted  = state == S_HALT;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_FETCH;
            cls       <= CL_ILL;
            cnt       <= '0;
            armed     <= 1'b0;
            bus_error <= 1'b0;
`ifdef MC_ILLEGAL_TRAP_EN
            illegal_insn <= 1'b0;
`endif
        end else begin
            state <= state_n;
            armed <= 1'b1;
            // Only stalled request cycles accumulate; any other cycle (incl. state entry) clears.
            cnt   <= (mem.mem_req && !mem.mem_ready) ? cnt + 1'b1 : '0;
            if (state == S_DECODE) cls <= dec_cls;
            if (timeout) bus_error <= 1'b1;
`ifdef MC_ILLEGAL_TRAP_EN
            if (state == S_DECODE && dec_cls == CL_ILL) illegal_insn <= 1'b1;
`endif
        end
    end

    always_comb begin
        state_n       = state;
        mem.mem_req   = 1'b0;
        mem.mem_we    = 1'b0;
        mem.mem_iaddr = 1'b1;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_src        = PC_PLUS4;
        reg_write     = 1'b0;
        wb_sel        = WB_ALU;
        alu_a_sel     = A_RS1;
        alu_b_sel     = B_RS2;
        alu_op_mode   = MODE_ADD;
        retire        = 1'b0;
        case (state)
            S_FETCH: begin
                if (timeout) state_n = S_HALT;
                else if (armed) begin
                    mem.mem_req = 1'b1;
                    ir_write    = mem.mem_ready;
                    state_n     = mem.mem_ready ? S_DECODE : S_FETCH;
                end
            end
            S_DECODE: begin
                if (dec_cls == CL_ILL) begin
`ifdef MC_ILLEGAL_TRAP_EN
                    state_n = S_HALT;
`else
                    pc_write = 1'b1;
                    retire   = 1'b1;
                    state_n  = S_FETCH;
`endif
                end else state_n = S_EXEC;
            end
            S_EXEC: begin
                alu_a_sel   = (cls == CL_JAL || cls == CL_AUIPC) ? A_PC : (cls == CL_LUI) ? A_ZERO : A_RS1;
                alu_b_sel   = (cls == CL_R || cls == CL_BRANCH) ? B_RS2 : B_IMM;
                alu_op_mode = (cls == CL_R || cls == CL_OPIMM) ? MODE_FUNCT :
                              (cls == CL_BRANCH) ? MODE_SUB : MODE_ADD;
                if (cls == CL_BRANCH) begin
                    pc_write = 1'b1;
                    pc_src   = branch_taken(funct3, alu_zero, alu_lt) ? PC_BRANCH : PC_PLUS4;
                    retire   = 1'b1;
                    state_n  = S_FETCH;
                end else state_n = (cls == CL_LOAD || cls == CL_STORE) ? S_MEM : S_WB;
            end
            S_MEM: begin
                mem.mem_iaddr = 1'b0;
                if (timeout) state_n = S_HALT;
                else begin
                    mem.mem_req = 1'b1;
                    mem.mem_we  = cls == CL_STORE;
                    if (mem.mem_ready && cls == CL_STORE) begin
                        pc_write = 1'b1;
                        retire   = 1'b1;
                        state_n  = S_FETCH;
                    end else if (mem.mem_ready) state_n = S_WB;
                end
            end
            S_WB: begin
                reg_write = 1'b1;
                wb_sel    = (cls == CL_LOAD) ? WB_MEM : jump ? WB_PC4 : WB_ALU;
                pc_write  = 1'b1;
                pc_src    = jump ? PC_ALU : PC_PLUS4;
                retire    = 1'b1;
                state_n   = S_FETCH;
            end
            S_HALT: state_n = S_HALT;
            default: state_n = S_FETCH;
        endcase
    end

endmodule
